// File: rtl/uart_apb4_mch_regmap_if.sv
// APB4 slave-port signal bundle for the multi-channel UART register map.
interface uart_apb4_mch_regmap_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic [3:0]                pstrb;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic                      pready;
    logic                      pslverr;
    logic [31:0]               prdata;

    modport master (
        output paddr, pwdata, pstrb, pwrite, psel, penable,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, pwdata, pstrb, pwrite, psel, penable,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/uart_apb4_mch_regmap.sv
// APB4 register map for NUM_CHANNELS UART channels: per-channel CTRL/BIT_LENGTH/IRQ
// registers, FIFO push/pop strobes, W1C interrupt status and programmable wait states.
module uart_apb4_mch_regmap #(
    parameter int NUM_CHANNELS   = 4,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CH_STRIDE      = 64,
    parameter int WAIT_STATES    = 0,
    parameter int IRQ_EVENTS_NUM = 4,
    parameter int BIT_LEN_RESET  = 1000,
    parameter int UFIFO_DEPTH    = 16,
    parameter int DFIFO_DEPTH    = 16
) (
    input  logic                                     i_apb_pclk,
    input  logic                                     i_apb_preset,
    uart_apb4_mch_regmap_if.slave                    apb,
    input  logic [NUM_CHANNELS*IRQ_EVENTS_NUM-1:0]   i_irq_events,
    input  logic [NUM_CHANNELS*8-1:0]                i_ufifo_data,
    input  logic [NUM_CHANNELS-1:0]                  i_ufifo_empty,
    input  logic [NUM_CHANNELS-1:0]                  i_ufifo_full,
    input  logic [NUM_CHANNELS-1:0]                  i_dfifo_empty,
    input  logic [NUM_CHANNELS-1:0]                  i_dfifo_full,
    input  logic [NUM_CHANNELS-1:0]                  i_rx_busy,
    input  logic [NUM_CHANNELS-1:0]                  i_tx_busy,
    output logic [NUM_CHANNELS-1:0]                  o_ufifo_pop,
    output logic [NUM_CHANNELS-1:0]                  o_dfifo_push,
    output logic [7:0]                               o_dfifo_data,
    output logic [NUM_CHANNELS*32-1:0]               o_ctrl,
    output logic [NUM_CHANNELS*32-1:0]               o_bit_length,
    output logic [NUM_CHANNELS-1:0]                  o_irq,
    output logic                                     o_irq_any
);
    localparam int OFF_W = $clog2(CH_STRIDE);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int IE    = IRQ_EVENTS_NUM;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                      state, state_nxt;
    logic [3:0]                  cnt;
    logic [APB_ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  strb_q;
    logic                        write_q;
    logic                        slverr_q;
    logic [31:0]                 prdata_q;

    logic [31:0]                 ctrl_q   [NUM_CHANNELS];
    logic [31:0]                 bitlen_q [NUM_CHANNELS];
    logic [IE-1:0]               mask_q   [NUM_CHANNELS];
    logic [IE-1:0]               status_q [NUM_CHANNELS];
    logic [IE-1:0]               status_nxt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]     irq_q;

    logic [APB_ADDR_WIDTH-OFF_W-1:0] ch_full;
    logic [CH_W-1:0]             ch;
    logic [OFF_W-1:0]            off;
    logic [2:0]                  idx;
    logic                        start, last_wait, commit, acc_err;
    logic [31:0]                 rd_data, smask;
    logic [7:0]                  ufifo_head;

    function automatic logic [31:0] strb_mask(input logic [3:0] st);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st[b]}};
        return m;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
        logic [31:0] m;
        m = strb_mask(st);
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [IE-1:0] mask_merge(input logic [IE-1:0] old, input logic [31:0] wd,
                                                 input logic [3:0] st);
        logic [31:0] r;
        r = byte_merge(32'(old), wd, st);
        return r[IE-1:0];
    endfunction

    assign ch_full   = addr_q[APB_ADDR_WIDTH-1:OFF_W];
    assign ch        = ch_full[CH_W-1:0];
    assign off       = addr_q[OFF_W-1:0];
    assign idx       = off[4:2];
    assign start     = apb.psel & apb.penable;
    assign last_wait = (state == S_WAIT) && (cnt == 4'd0);
    assign commit    = (state == S_RESP) && !slverr_q && write_q;
    assign smask     = strb_mask(strb_q);
    assign ufifo_head = i_ufifo_data[ch*8 +: 8];

    always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
        if (i_apb_preset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) cnt <= 4'(WAIT_STATES);
            else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        apb.pready  = (state == S_RESP);
        o_ufifo_pop = '0;
        if (state == S_RESP && !slverr_q && !write_q && idx == 3'd5 && !i_ufifo_empty[ch])
            o_ufifo_pop[ch] = 1'b1;
    end

    // Request fields are held for the whole access; they need no reset.
    always_ff @(posedge i_apb_pclk) begin
        if (state == S_IDLE && start) begin
            addr_q  <= apb.paddr;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            write_q <= apb.pwrite;
        end
    end

    always_comb begin
        acc_err = (32'(ch_full) >= NUM_CHANNELS) || (32'(off) > 32'h1C) || (addr_q[1:0] != 2'b00)
               || (write_q && idx >= 3'd5) || (!write_q && idx == 3'd4)
               || (write_q && idx == 3'd4 && (i_dfifo_full[ch] || !strb_q[0]));
        case (idx)
            3'd0:    rd_data = ctrl_q[ch];
            3'd1:    rd_data = bitlen_q[ch];
            3'd2:    rd_data = 32'(mask_q[ch]);
            3'd3:    rd_data = 32'(status_q[ch]);
            3'd5:    rd_data = {23'b0, !i_ufifo_empty[ch], ufifo_head};
            3'd6:    rd_data = {21'b0, i_dfifo_full[ch], i_dfifo_empty[ch], i_tx_busy[ch], 5'b0,
                                i_ufifo_full[ch], i_ufifo_empty[ch], i_rx_busy[ch]};
            3'd7:    rd_data = {8'h02, 8'h00, 8'(UFIFO_DEPTH), 8'(DFIFO_DEPTH)};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
        if (i_apb_preset) begin
            slverr_q <= 1'b0;
            prdata_q <= 32'd0;
        end else if (last_wait) begin
            slverr_q <= acc_err;
            prdata_q <= (acc_err || write_q) ? 32'd0 : rd_data;
        end
    end

    assign apb.pslverr = slverr_q;
    assign apb.prdata  = prdata_q;

    // A status bit whose event coincides with its W1C clear stays set.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            status_nxt[c] = status_q[c] | i_irq_events[c*IE +: IE];
            if (commit && idx == 3'd3 && int'(ch) == c)
                status_nxt[c] = (status_q[c] & ~(wdata_q[IE-1:0] & smask[IE-1:0]))
                              | i_irq_events[c*IE +: IE];
        end
    end

    always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
        if (i_apb_preset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ctrl_q[c]   <= 32'd0;
                bitlen_q[c] <= 32'(BIT_LEN_RESET);
                mask_q[c]   <= '0;
                status_q[c] <= '0;
            end
            irq_q        <= '0;
            o_dfifo_push <= '0;
            o_dfifo_data <= 8'd0;
        end else begin
            o_dfifo_push <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                status_q[c] <= status_nxt[c];
                irq_q[c]    <= ctrl_q[c][0] & |(status_q[c] & mask_q[c]);
                if (commit && int'(ch) == c) begin
                    case (idx)
                        3'd0: ctrl_q[c]   <= byte_merge(ctrl_q[c], wdata_q, strb_q);
                        3'd1: bitlen_q[c] <= byte_merge(bitlen_q[c], wdata_q, strb_q);
                        3'd2: mask_q[c]   <= mask_merge(mask_q[c], wdata_q, strb_q);
                        3'd4: begin
                            o_dfifo_push[c] <= 1'b1;
                            o_dfifo_data    <= wdata_q[7:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            o_ctrl[c*32 +: 32]       = ctrl_q[c];
            o_bit_length[c*32 +: 32] = bitlen_q[c];
        end
    end

    assign o_irq     = irq_q;
    assign o_irq_any = |irq_q;
endmodule

// File: tb/tb_uart_apb4_mch_regmap.sv
// Self-checking bench: directed scenarios plus randomized accesses against a register-level model.
module tb_uart_apb4_mch_regmap;
    localparam int NC = 4;
    localparam int IE = 4;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst, rst3;
    always #5 clk = ~clk;

    uart_apb4_mch_regmap_if #(.APB_ADDR_WIDTH(AW)) bus0 ();
    uart_apb4_mch_regmap_if #(.APB_ADDR_WIDTH(AW)) bus3 ();

    logic [NC*IE-1:0] events;
    logic [NC*8-1:0]  ufifo_data;
    logic [NC-1:0]    ufifo_empty, ufifo_full, dfifo_empty, dfifo_full, rx_busy, tx_busy;
    logic [NC-1:0]    pop0, push0, irq0, pop3, push3, irq3;
    logic [7:0]       ddata0, ddata3;
    logic [NC*32-1:0] ctrl0, bitlen0, ctrl3, bitlen3;
    logic             irq_any0, irq_any3;

    uart_apb4_mch_regmap #(.NUM_CHANNELS(NC), .APB_ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .i_apb_pclk(clk), .i_apb_preset(rst), .apb(bus0.slave),
        .i_irq_events(events), .i_ufifo_data(ufifo_data), .i_ufifo_empty(ufifo_empty),
        .i_ufifo_full(ufifo_full), .i_dfifo_empty(dfifo_empty), .i_dfifo_full(dfifo_full),
        .i_rx_busy(rx_busy), .i_tx_busy(tx_busy), .o_ufifo_pop(pop0), .o_dfifo_push(push0),
        .o_dfifo_data(ddata0), .o_ctrl(ctrl0), .o_bit_length(bitlen0), .o_irq(irq0),
        .o_irq_any(irq_any0));

    uart_apb4_mch_regmap #(.NUM_CHANNELS(NC), .APB_ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
        .i_apb_pclk(clk), .i_apb_preset(rst3), .apb(bus3.slave),
        .i_irq_events(events), .i_ufifo_data(ufifo_data), .i_ufifo_empty(ufifo_empty),
        .i_ufifo_full(ufifo_full), .i_dfifo_empty(dfifo_empty), .i_dfifo_full(dfifo_full),
        .i_rx_busy(rx_busy), .i_tx_busy(tx_busy), .o_ufifo_pop(pop3), .o_dfifo_push(push3),
        .o_dfifo_data(ddata3), .o_ctrl(ctrl3), .o_bit_length(bitlen3), .o_irq(irq3),
        .o_irq_any(irq_any3));

    int errors = 0;
    int checks = 0;

    // Reference model of dut0's registers
    logic [31:0]   m_ctrl   [NC];
    logic [31:0]   m_bitlen [NC];
    logic [IE-1:0] m_mask   [NC];
    logic [IE-1:0] m_status [NC];

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_ctrl[c] = 0; m_bitlen[c] = 32'd1000; m_mask[c] = 0; m_status[c] = 0;
        end
    endtask

    task automatic model_access(input logic w, input logic [11:0] a, input logic [31:0] wd,
                                input logic [3:0] st, output logic [31:0] rd, output logic err,
                                output logic [NC-1:0] pop, output logic [NC-1:0] push);
        int ch, off;
        logic [31:0] m;
        ch = int'(a) / 64;
        off = int'(a) % 64;
        rd = 0; err = 0; pop = 0; push = 0;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = st[b] ? 8'hFF : 8'h00;
        if (ch >= NC || off > 'h1C || (off % 4) != 0) err = 1;
        else if (w && off >= 'h14) err = 1;
        else if (!w && off == 'h10) err = 1;
        else if (w && off == 'h10 && (dfifo_full[ch] || !st[0])) err = 1;
        if (!err && w) begin
            case (off)
                'h00: m_ctrl[ch]   = (m_ctrl[ch] & ~m) | (wd & m);
                'h04: m_bitlen[ch] = (m_bitlen[ch] & ~m) | (wd & m);
                'h08: m_mask[ch]   = IE'(((32'(m_mask[ch])) & ~m) | (wd & m));
                'h0C: m_status[ch] = m_status[ch] & ~IE'(wd & m);
                'h10: push[ch] = 1;
                default: ;
            endcase
        end else if (!err) begin
            case (off)
                'h00: rd = m_ctrl[ch];
                'h04: rd = m_bitlen[ch];
                'h08: rd = 32'(m_mask[ch]);
                'h0C: rd = 32'(m_status[ch]);
                'h14: begin
                    rd = ufifo_empty[ch] ? 32'(ufifo_data[ch*8 +: 8]) : 32'h100 + 32'(ufifo_data[ch*8 +: 8]);
                    pop[ch] = !ufifo_empty[ch];
                end
                'h18: begin
                    rd[0] = rx_busy[ch]; rd[1] = ufifo_empty[ch]; rd[2] = ufifo_full[ch];
                    rd[8] = tx_busy[ch]; rd[9] = dfifo_empty[ch]; rd[10] = dfifo_full[ch];
                end
                'h1C: rd = 32'h0200_1010;
                default: ;
            endcase
        end
    endtask

    function automatic logic [NC-1:0] model_irq();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = m_ctrl[c][0] & |(m_status[c] & m_mask[c]);
        return r;
    endfunction

    task automatic drive(input bit sel3, input logic sel, input logic en, input logic w,
                         input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
        if (sel3) begin
            bus3.psel = sel; bus3.penable = en; bus3.pwrite = w;
            bus3.paddr = a; bus3.pwdata = wd; bus3.pstrb = st;
        end else begin
            bus0.psel = sel; bus0.penable = en; bus0.pwrite = w;
            bus0.paddr = a; bus0.pwdata = wd; bus0.pstrb = st;
        end
    endtask

    // One APB transfer; ev is pulsed on the edge that ends the response cycle.
    task automatic apb(input bit sel3, input logic w, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [NC*IE-1:0] ev,
                       output logic [31:0] rd, output logic err, output int lat,
                       output logic [NC-1:0] pop, output logic [NC-1:0] push, output logic [7:0] dd);
        logic rdy;
        @(negedge clk); drive(sel3, 1, 0, w, a, wd, st);
        @(negedge clk); drive(sel3, 1, 1, w, a, wd, st);
        @(posedge clk); #1;
        lat = 0;
        rdy = sel3 ? bus3.pready : bus0.pready;
        while (!rdy && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            rdy = sel3 ? bus3.pready : bus0.pready;
        end
        rd  = sel3 ? bus3.prdata : bus0.prdata;
        err = sel3 ? bus3.pslverr : bus0.pslverr;
        pop = sel3 ? pop3 : pop0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h: no pready within %0d cycles", a, lat);
        end
        drive(sel3, 0, 0, 0, 0, 0, 0);
        events = ev;
        @(posedge clk); #1;
        events = '0;
        push = sel3 ? push3 : push0;
        dd   = sel3 ? ddata3 : ddata0;
        if (!sel3) for (int c = 0; c < NC; c++) m_status[c] |= ev[c*IE +: IE];
    endtask

    task automatic acc0(input logic w, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic [NC*IE-1:0] ev, output logic [31:0] rd, output logic err,
                        output int lat, output logic [NC-1:0] pop, output logic [NC-1:0] push,
                        output logic [7:0] dd);
        logic [31:0] xr; logic xe; logic [NC-1:0] xp, xq;
        model_access(w, a, wd, st, xr, xe, xp, xq);
        apb(0, w, a, wd, st, ev, rd, err, lat, pop, push, dd);
    endtask

    task automatic pulse_ev(input logic [NC*IE-1:0] v);
        @(negedge clk); events = v;
        @(negedge clk); events = '0;
        for (int c = 0; c < NC; c++) m_status[c] |= v[c*IE +: IE];
    endtask

    logic [31:0] rd; logic err; int lat; logic [NC-1:0] pop, push; logic [7:0] dd;

    task automatic test_reset();
        checks++; if (bus0.pready !== 1'b0 || bus0.pslverr !== 1'b0 || bus0.prdata !== 32'd0) begin
            errors++; $display("FAIL reset_apb: got rdy=%b err=%b rd=%h want 0 0 0", bus0.pready, bus0.pslverr, bus0.prdata); end
        checks++; if (ctrl0 !== '0 || irq0 !== '0 || irq_any0 !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got ctrl=%h irq=%b any=%b want 0", ctrl0, irq0, irq_any0); end
        checks++; if (bitlen0 !== {4{32'd1000}} || bitlen3 !== {4{32'd1000}}) begin
            errors++; $display("FAIL reset_bitlen: got %h / %h want 4x000003e8", bitlen0, bitlen3); end
        checks++; if (push0 !== '0 || pop0 !== '0 || ddata0 !== 8'd0) begin
            errors++; $display("FAIL reset_fifo: got push=%b pop=%b dd=%h want 0", push0, pop0, ddata0); end
    endtask

    task automatic test_read_bitlen();
        acc0(0, 12'h044, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bitlen_latency: got %0d want 1", lat); end
        checks++; if (rd !== 32'd1000 || err !== 1'b0) begin
            errors++; $display("FAIL bitlen_read: got rd=%h err=%b want 000003e8 0", rd, err); end
        checks++; if (bus0.pready !== 1'b0) begin
            errors++; $display("FAIL pready_b2b: got %b want 0", bus0.pready); end
    endtask

    task automatic test_strobe_write();
        acc0(1, 12'h000, 32'hAABBCCDD, 4'b0101, '0, rd, err, lat, pop, push, dd);
        checks++; if (ctrl0[31:0] !== 32'h00BB00DD) begin
            errors++; $display("FAIL strobe_octrl: got %h want 00bb00dd", ctrl0[31:0]); end
        acc0(0, 12'h000, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (rd !== 32'h00BB00DD || err !== 1'b0) begin
            errors++; $display("FAIL strobe_read: got rd=%h err=%b want 00bb00dd 0", rd, err); end
    endtask

    task automatic test_irq();
        acc0(1, 12'h080, 32'h1, 4'hF, '0, rd, err, lat, pop, push, dd);
        acc0(1, 12'h088, 32'h2, 4'hF, '0, rd, err, lat, pop, push, dd);
        pulse_ev(16'h0200);
        @(posedge clk); #1;
        checks++; if (irq0 !== 4'b0100 || irq_any0 !== 1'b1) begin
            errors++; $display("FAIL irq_set: got irq=%b any=%b want 0100 1", irq0, irq_any0); end
        acc0(1, 12'h08C, 32'h2, 4'hF, '0, rd, err, lat, pop, push, dd);
        @(posedge clk); #1;
        checks++; if (irq0 !== 4'b0000 || irq_any0 !== 1'b0) begin
            errors++; $display("FAIL irq_clear: got irq=%b any=%b want 0000 0", irq0, irq_any0); end
        pulse_ev(16'h0200);
        acc0(1, 12'h08C, 32'h2, 4'hF, 16'h0200, rd, err, lat, pop, push, dd);
        @(posedge clk); #1;
        checks++; if (irq0 !== 4'b0100) begin
            errors++; $display("FAIL irq_set_wins: got irq=%b want 0100", irq0); end
        acc0(0, 12'h08C, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL irq_status_read: got %h want 2", rd); end
    endtask

    task automatic test_dfifo();
        dfifo_full = '0;
        acc0(1, 12'h0D0, 32'h0000005A, 4'h1, '0, rd, err, lat, pop, push, dd);
        checks++; if (push !== 4'b1000 || dd !== 8'h5A || err !== 1'b0) begin
            errors++; $display("FAIL dfifo_push: got push=%b dd=%h err=%b want 1000 5a 0", push, dd, err); end
        @(posedge clk); #1;
        checks++; if (push0 !== 4'b0000) begin errors++; $display("FAIL dfifo_one_pulse: got %b want 0000", push0); end
        dfifo_full = 4'b1000;
        acc0(1, 12'h0D0, 32'h0000005A, 4'h1, '0, rd, err, lat, pop, push, dd);
        checks++; if (push !== 4'b0000 || err !== 1'b1) begin
            errors++; $display("FAIL dfifo_full: got push=%b err=%b want 0000 1", push, err); end
        dfifo_full = '0;
        acc0(1, 12'h0D0, 32'h0000005A, 4'h2, '0, rd, err, lat, pop, push, dd);
        checks++; if (push !== 4'b0000 || err !== 1'b1) begin
            errors++; $display("FAIL dfifo_strb: got push=%b err=%b want 0000 1", push, err); end
    endtask

    task automatic test_ufifo();
        ufifo_data = 32'h0000_0033; ufifo_empty = 4'b1110;
        acc0(0, 12'h014, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (rd !== 32'h133 || pop !== 4'b0001 || err !== 1'b0) begin
            errors++; $display("FAIL ufifo_read: got rd=%h pop=%b err=%b want 133 0001 0", rd, pop, err); end
        checks++; if (pop0 !== 4'b0000) begin errors++; $display("FAIL ufifo_one_pop: got %b want 0000", pop0); end
        ufifo_data = '0; ufifo_empty = 4'b1111;
        acc0(0, 12'h014, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (rd !== 32'h0 || pop !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL ufifo_empty: got rd=%h pop=%b err=%b want 0 0000 0", rd, pop, err); end
    endtask

    task automatic test_errors();
        acc0(0, 12'h104, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL err_bad_ch: got err=%b rd=%h want 1 0", err, rd); end
        acc0(1, 12'h018, 32'hFFFF, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_write_stats: got %b want 1", err); end
        acc0(0, 12'h010, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL err_read_dfifo: got err=%b rd=%h want 1 0", err, rd); end
        acc0(1, 12'h046, 32'h1234, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (err !== 1'b1 || bitlen0[63:32] !== 32'd1000) begin
            errors++; $display("FAIL err_misaligned: got err=%b bitlen=%h want 1 3e8", err, bitlen0[63:32]); end
        acc0(0, 12'h020, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_off_range: got %b want 1", err); end
        acc0(0, 12'h0DC, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (rd !== 32'h0200_1010 || err !== 1'b0) begin
            errors++; $display("FAIL hwinfo: got rd=%h err=%b want 02001010 0", rd, err); end
    endtask

    task automatic test_wait_states();
        apb(1, 0, 12'h004, 0, 4'hF, '0, rd, err, lat, pop, push, dd);
        checks++; if (lat !== 4 || rd !== 32'd1000 || err !== 1'b0) begin
            errors++; $display("FAIL ws3_read: got lat=%0d rd=%h err=%b want 4 3e8 0", lat, rd, err); end
        checks++; if (bus3.pready !== 1'b0) begin errors++; $display("FAIL ws3_b2b: got %b want 0", bus3.pready); end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        seen = 0;
        @(negedge clk); drive(1, 1, 0, 1, 12'h004, 32'h1234, 4'hF);
        @(negedge clk); drive(1, 1, 1, 1, 12'h004, 32'h1234, 4'hF);
        @(posedge clk); #1;
        @(negedge clk); rst3 = 1; drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst3 = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus3.pready) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_pready: got 1 want 0"); end
        checks++; if (bitlen3[31:0] !== 32'd1000) begin
            errors++; $display("FAIL rst_wait_reg: got %h want 3e8", bitlen3[31:0]); end
    endtask

    task automatic test_random();
        int offs[11];
        logic [31:0] xr; logic xe; logic [NC-1:0] xp, xq;
        logic [NC*IE-1:0] ev;
        logic w; logic [11:0] a; logic [31:0] wd; logic [3:0] st;
        offs = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h3C, 'h06};
        for (int it = 0; it < 80; it++) begin
            a  = 12'($urandom_range(0, 4) * 64 + offs[$urandom_range(0, 10)]);
            w  = 1'($urandom);
            wd = $urandom;
            st = 4'($urandom);
            ev = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '0;
            ufifo_empty = 4'($urandom); ufifo_full = 4'($urandom);
            dfifo_empty = 4'($urandom); dfifo_full = 4'($urandom);
            rx_busy = 4'($urandom); tx_busy = 4'($urandom);
            ufifo_data = $urandom;
            for (int c = 0; c < NC; c++) if (ufifo_empty[c]) ufifo_data[c*8 +: 8] = 8'h00;
            model_access(w, a, wd, st, xr, xe, xp, xq);
            apb(0, w, a, wd, st, ev, rd, err, lat, pop, push, dd);
            checks++; if (err !== xe || (!w && rd !== xr)) begin
                errors++; $display("FAIL rand_resp w=%b a=%h: got err=%b rd=%h want %b %h", w, a, err, rd, xe, xr); end
            checks++; if (pop !== xp || push !== xq || (xq != 0 && dd !== wd[7:0])) begin
                errors++; $display("FAIL rand_fifo a=%h: got pop=%b push=%b dd=%h want %b %b %h", a, pop, push, dd, xp, xq, wd[7:0]); end
            checks++; if (ctrl0 !== {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}
                          || bitlen0 !== {m_bitlen[3], m_bitlen[2], m_bitlen[1], m_bitlen[0]}) begin
                errors++; $display("FAIL rand_regs a=%h: got ctrl=%h bl=%h", a, ctrl0, bitlen0); end
            @(posedge clk); #1;
            checks++; if (irq0 !== model_irq() || irq_any0 !== |model_irq()) begin
                errors++; $display("FAIL rand_irq: got %b want %b", irq0, model_irq()); end
        end
    endtask

    initial begin
        rst = 1; rst3 = 1;
        events = '0; ufifo_data = '0; ufifo_empty = '1; ufifo_full = '0;
        dfifo_empty = '1; dfifo_full = '0; rx_busy = '0; tx_busy = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0; rst3 = 0;
        @(posedge clk); #1;
        test_reset();
        test_read_bitlen();
        test_strobe_write();
        test_irq();
        test_dfifo();
        test_ufifo();
        test_errors();
        test_wait_states();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
